// File: rtl/rd_ctrl_mc_if.sv
// Bus bundle for the multi-channel cache read controller.
// Carries the accelerator read channels, the cache lookup/tag interface,
// the write-controller conflict handshake, the line-fetch interface and the
// data-memory read port.
//   master : the read controller (drives ready, lookup, fetch, mem read)
//   slave  : the surrounding system (accelerators, cache, fetch, memory)
interface rd_ctrl_mc_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int list_depth = 4,
  parameter int list_width = 32,
  parameter int num_ch     = 2
);
  localparam int TW = $clog2(list_depth);
  localparam int OW = $clog2(list_width);

  // accelerator read channels
  logic [num_ch-1:0]            acc_rd_valid;
  logic [num_ch-1:0]            acc_rd_ready;
  logic [num_ch*addr_width-1:0] acc_rd_addr;
  logic [data_width-1:0]        acc_rd_data;
  logic [num_ch-1:0]            acc_rd_data_valid;
  // cache lookup / tag interface
  logic [addr_width-1:0]        acc_index;
  logic [2:0]                   acc_status;
  logic [1:0]                   acc_cmd;
  logic [TW-1:0]                acc_tag;
  logic                         acc_req;
  logic [TW-1:0]                return_tag;
  logic [addr_width-1:0]        return_index;
  // write-controller conflict handshake
  logic [2:0]                   proc_status_r;
  logic [addr_width-1:0]        proc_addr_r;
  logic [2:0]                   proc_status_w;
  logic [addr_width-1:0]        proc_addr_w;
  // line fetch
  logic [1:0]                   fetch_cmd;
  logic                         fetch_req;
  logic [TW-1:0]                fetch_tag;
  logic [addr_width-1:0]        fetch_addr;
  logic [addr_width-1:0]        fetch_addr_pre;
  logic                         fetch_gnt;
  logic                         fetch_done;
  // data memory read port
  logic [TW+OW-1:0]             mem_raddr;
  logic                         mem_ren;
  logic                         mem_rready;
  logic [data_width-1:0]        mem_rdata;
  logic                         mem_rdata_valid;

  modport master (
    input  acc_rd_valid, acc_rd_addr, acc_status, return_tag, return_index,
           proc_status_w, proc_addr_w, fetch_gnt, fetch_done,
           mem_rready, mem_rdata, mem_rdata_valid,
    output acc_rd_ready, acc_rd_data, acc_rd_data_valid, acc_index, acc_cmd,
           acc_tag, acc_req, proc_status_r, proc_addr_r, fetch_cmd, fetch_req,
           fetch_tag, fetch_addr, fetch_addr_pre, mem_raddr, mem_ren
  );

  modport slave (
    output acc_rd_valid, acc_rd_addr, acc_status, return_tag, return_index,
           proc_status_w, proc_addr_w, fetch_gnt, fetch_done,
           mem_rready, mem_rdata, mem_rdata_valid,
    input  acc_rd_ready, acc_rd_data, acc_rd_data_valid, acc_index, acc_cmd,
           acc_tag, acc_req, proc_status_r, proc_addr_r, fetch_cmd, fetch_req,
           fetch_tag, fetch_addr, fetch_addr_pre, mem_raddr, mem_ren
  );
endinterface

// File: rtl/rd_ctrl_mc.sv
// Multi-channel cache read controller.
// Arbitrates num_ch accelerator read channels round-robin onto one cache
// lookup interface, one line-fetch interface and one data-memory read port.
// A response-ID FIFO records which channel owns each accepted memory read so
// the in-order read data can be steered back with a one-hot strobe.
// After a write-side conflict clears, the line is looked up again rather
// than trusting the tag seen before the conflict.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : rd_ctrl_mc_if.master (accelerator, lookup, conflict, fetch, mem)
module rd_ctrl_mc #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int list_depth = 4,
  parameter int list_width = 32,
  parameter int num_ch     = 2,
  parameter int rsp_depth  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rd_ctrl_mc_if.master bus
);
  localparam int TW = $clog2(list_depth);
  localparam int OW = $clog2(list_width);
  localparam int CW = (num_ch > 1) ? $clog2(num_ch) : 1;
  localparam int PW = $clog2(rsp_depth);

  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    WAIT_MEM       = 4'd1,
    CHECK_CONFLICT = 4'd2,
    WAIT_CONFLICT  = 4'd3,
    RELOOKUP       = 4'd4,
    ALLOCATE_LINE  = 4'd5,
    FETCH_REQ      = 4'd6,
    WAIT_FETCH     = 4'd7,
    ACC_MEM        = 4'd8
  } state_t;

  state_t                state_r, state_n;
  logic                  run_r;
  logic [CW-1:0]         rr_ptr_r;
  logic [addr_width-1:0] addr_r;
  logic [CW-1:0]         ch_r;
  logic [TW-1:0]         tag_r;
  logic [addr_width-1:0] index_r;
  logic                  dirty_r;
  logic [1:0]            fetch_cmd_r;

  logic [CW-1:0]         fifo_mem_r [rsp_depth];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW:0]           count_r;

  logic [CW-1:0]         grant_s;
  logic                  grant_vld_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  hs_s;
  logic [num_ch-1:0]     ready_s;
  logic [num_ch-1:0]     rsp_strobe_s;
  logic [addr_width-1:0] cur_addr_s;
  logic [addr_width-1:0] line_s;
  logic                  hit_s;
  logic                  miss_s;
  logic                  dirty_s;
  logic                  conflict_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CW-1:0]         push_id_s;

  logic                  acc_req_s;
  logic [1:0]            acc_cmd_s;
  logic                  mem_ren_s;
  logic [TW+OW-1:0]      mem_raddr_s;
  logic                  fetch_req_s;
  logic [2:0]            proc_status_s;
  logic                  load_hit_tag_s;
  logic                  load_miss_s;
  logic                  alloc_s;

  // Round-robin search: scan downward so the nearest valid channel at or
  // above rr_ptr (with wrap) is the last one written and therefore wins.
  always_comb begin
    grant_s     = rr_ptr_r;
    grant_vld_s = 1'b0;
    for (int k = num_ch - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % num_ch;
      if (bus.acc_rd_valid[idx]) begin
        grant_s     = CW'(idx);
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign full_s  = (count_r == (PW+1)'(rsp_depth));
  assign empty_s = (count_r == {(PW+1){1'b0}});
  // run_r keeps grants off while reset is held and for the release cycle
  assign hs_s    = run_r && (state_r == IDLE) && grant_vld_s && !full_s;

  // In IDLE the lookup uses the live address of the granted channel; in all
  // other states it uses the address latched at the handshake.
  assign cur_addr_s = (state_r == IDLE) ? bus.acc_rd_addr[grant_s*addr_width +: addr_width]
                                        : addr_r;
  assign line_s     = {cur_addr_s[addr_width-1:OW], {OW{1'b0}}};

  assign hit_s      = (bus.acc_status == 3'b001);
  assign dirty_s    = (bus.acc_status == 3'b100);
  assign miss_s     = (bus.acc_status == 3'b000) || dirty_s;
  assign conflict_s = ((bus.proc_status_w == 3'b001) || (bus.proc_status_w == 3'b010)) &&
                      (bus.proc_addr_w == line_s);

  assign pop_s     = bus.mem_rdata_valid && !empty_s;
  assign push_s    = mem_ren_s && bus.mem_rready && (!full_s || pop_s);
  assign push_id_s = (state_r == IDLE) ? grant_s : ch_r;

  // One-hot accept and return strobes.
  always_comb begin
    ready_s      = {num_ch{1'b0}};
    rsp_strobe_s = {num_ch{1'b0}};
    for (int i = 0; i < num_ch; i++) begin
      ready_s[i]      = hs_s && (grant_s == CW'(i));
      rsp_strobe_s[i] = pop_s && (fifo_mem_r[rd_ptr_r] == CW'(i));
    end
  end

  // Next-state and per-state interface outputs.
  always_comb begin
    state_n        = state_r;
    acc_req_s      = 1'b0;
    acc_cmd_s      = 2'b00;
    mem_ren_s      = 1'b0;
    mem_raddr_s    = {tag_r, addr_r[OW-1:0]};
    fetch_req_s    = 1'b0;
    proc_status_s  = 3'b000;
    load_hit_tag_s = 1'b0;
    load_miss_s    = 1'b0;
    alloc_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          acc_req_s = 1'b1;
          if (hit_s) begin
            mem_ren_s      = 1'b1;
            mem_raddr_s    = {bus.return_tag, cur_addr_s[OW-1:0]};
            load_hit_tag_s = 1'b1;
            state_n        = bus.mem_rready ? IDLE : WAIT_MEM;
          end else if (miss_s) begin
            load_miss_s = 1'b1;
            state_n     = CHECK_CONFLICT;
          end else begin
            state_n = RELOOKUP;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_MEM: begin
        mem_ren_s = 1'b1;
        if (bus.mem_rready) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT_MEM;
        end
      end
      CHECK_CONFLICT: begin
        proc_status_s = 3'b001;
        if (conflict_s) begin
          state_n = WAIT_CONFLICT;
        end else begin
          state_n = ALLOCATE_LINE;
        end
      end
      WAIT_CONFLICT: begin
        if (bus.proc_status_w == 3'b011) begin
          state_n = RELOOKUP;
        end else begin
          state_n = WAIT_CONFLICT;
        end
      end
      RELOOKUP: begin
        acc_req_s = 1'b1;
        if (hit_s) begin
          load_hit_tag_s = 1'b1;
          state_n        = ACC_MEM;
        end else if (miss_s) begin
          load_miss_s = 1'b1;
          state_n     = CHECK_CONFLICT;
        end else begin
          state_n = RELOOKUP;
        end
      end
      ALLOCATE_LINE: begin
        acc_req_s     = 1'b1;
        acc_cmd_s     = 2'b10;
        proc_status_s = 3'b010;
        alloc_s       = 1'b1;
        state_n       = FETCH_REQ;
      end
      FETCH_REQ: begin
        proc_status_s = 3'b010;
        fetch_req_s   = 1'b1;
        if (bus.fetch_gnt) begin
          state_n = WAIT_FETCH;
        end else begin
          state_n = FETCH_REQ;
        end
      end
      WAIT_FETCH: begin
        proc_status_s = 3'b010;
        if (bus.fetch_done) begin
          state_n = ACC_MEM;
        end else begin
          state_n = WAIT_FETCH;
        end
      end
      ACC_MEM: begin
        mem_ren_s = 1'b1;
        if (bus.mem_rready) begin
          // touch the line so replacement sees it as recently used
          acc_req_s     = 1'b1;
          acc_cmd_s     = 2'b11;
          proc_status_s = 3'b011;
          state_n       = IDLE;
        end else begin
          proc_status_s = 3'b010;
          state_n       = ACC_MEM;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register, arbitration pointer and per-request context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      run_r       <= 1'b0;
      rr_ptr_r    <= {CW{1'b0}};
      addr_r      <= {addr_width{1'b0}};
      ch_r        <= {CW{1'b0}};
      tag_r       <= {TW{1'b0}};
      index_r     <= {addr_width{1'b0}};
      dirty_r     <= 1'b0;
      fetch_cmd_r <= 2'b00;
    end else begin
      state_r <= state_n;
      run_r   <= 1'b1;
      if (hs_s) begin
        addr_r <= cur_addr_s;
        ch_r   <= grant_s;
        if (int'(grant_s) == num_ch - 1) begin
          rr_ptr_r <= {CW{1'b0}};
        end else begin
          rr_ptr_r <= grant_s + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      if (load_miss_s) begin
        dirty_r <= dirty_s;
      end
      if (alloc_s) begin
        tag_r       <= bus.return_tag;
        index_r     <= bus.return_index;
        fetch_cmd_r <= dirty_r ? 2'b10 : 2'b01;
      end else if (load_hit_tag_s) begin
        tag_r <= bus.return_tag;
      end
    end
  end

  // Response-ID FIFO: one entry per accepted memory read, popped on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < rsp_depth; i++) begin
        fifo_mem_r[i] <= {CW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= push_id_s;
        wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.acc_rd_ready      = ready_s;
  assign bus.acc_rd_data       = bus.mem_rdata;
  assign bus.acc_rd_data_valid = rsp_strobe_s;
  assign bus.acc_index         = line_s;
  assign bus.acc_cmd           = acc_cmd_s;
  assign bus.acc_tag           = tag_r;
  assign bus.acc_req           = acc_req_s;
  assign bus.proc_status_r     = proc_status_s;
  assign bus.proc_addr_r       = line_s;
  assign bus.fetch_cmd         = fetch_cmd_r;
  assign bus.fetch_req         = fetch_req_s;
  assign bus.fetch_tag         = tag_r;
  assign bus.fetch_addr        = line_s;
  assign bus.fetch_addr_pre    = index_r;
  assign bus.mem_raddr         = mem_raddr_s;
  assign bus.mem_ren           = mem_ren_s;
endmodule

// File: tb/tb_rd_ctrl_mc.sv
// Self-checking bench for rd_ctrl_mc (num_ch=2, rsp_depth=2, TW=2, OW=5).
// Inputs change on the falling edge and outputs are sampled 2 time units
// later. A small memory model returns data derived from the read address;
// expected responses are queued from the stimulus and popped on return.
module tb_rd_ctrl_mc;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  tag;
    logic        rv;
    logic [1:0]  exp_ready;
    logic [31:0] exp_idx;
    logic [6:0]  exp_raddr;
    int          exp_ch;
  } vec_t;

  exp_t       exp_q[$];
  logic [6:0] pend_q[$];
  vec_t       vecs[7];

  rd_ctrl_mc_if #(.addr_width(AW), .data_width(DW), .list_depth(4),
                  .list_width(32), .num_ch(2)) bus ();

  rd_ctrl_mc #(.addr_width(AW), .data_width(DW), .list_depth(4),
               .list_width(32), .num_ch(2), .rsp_depth(2))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(logic [6:0] r);
    return 32'hDA7A_0000 | {25'd0, r};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s act=empty exp=entry", name);
  endtask

  // memory model: record every accepted read address
  always begin
    @(negedge clk);
    #3;
    if (bus.mem_ren === 1'b1 && bus.mem_rready === 1'b1) pend_q.push_back(bus.mem_raddr);
  end

  // new cycle: pulses and request valids drop unless re-driven
  task automatic next_cyc();
    @(negedge clk);
    bus.acc_rd_valid    = 2'b00;
    bus.mem_rdata_valid = 1'b0;
    bus.fetch_gnt       = 1'b0;
    bus.fetch_done      = 1'b0;
  endtask

  task automatic drive_pop();
    if (pend_q.size() == 0) begin
      fail_now("mem_pending");
    end else begin
      bus.mem_rdata       = mdata(pend_q.pop_front());
      bus.mem_rdata_valid = 1'b1;
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      fail_now("scoreboard");
    end else begin
      e = exp_q.pop_front();
      chk("rsp_strobe", bus.acc_rd_data_valid, 64'(2'b01 << e.ch));
      chk("rsp_data", bus.acc_rd_data, e.data);
    end
  endtask

  task automatic ret();
    next_cyc();
    drive_pop();
    #2;
    check_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    //          valid  a0            a1            tag   rv    rdy    idx           raddr  ch
    vecs[0] = '{2'b11, 32'h0000_0040, 32'h0000_0080, 2'd1, 1'b0, 2'b01, 32'h0000_0040, 7'h20, 0};
    vecs[1] = '{2'b11, 32'h0000_0040, 32'h0000_0080, 2'd2, 1'b1, 2'b10, 32'h0000_0080, 7'h40, 1};
    vecs[2] = '{2'b10, 32'h0000_0000, 32'h0000_1234, 2'd3, 1'b1, 2'b10, 32'h0000_1220, 7'h74, 1};
    vecs[3] = '{2'b10, 32'h0000_0000, 32'h5555_555F, 2'd0, 1'b1, 2'b10, 32'h5555_5540, 7'h1F, 1};
    vecs[4] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 2'd3, 1'b1, 2'b10, 32'hFFFF_FFE0, 7'h7F, 1};
    vecs[5] = '{2'b11, 32'h0000_0021, 32'h0000_0080, 2'd2, 1'b1, 2'b01, 32'h0000_0020, 7'h41, 0};
    vecs[6] = '{2'b01, 32'h0000_003C, 32'h0000_0080, 2'd1, 1'b1, 2'b01, 32'h0000_0020, 7'h3C, 0};

    rst_n               = 1'b0;
    bus.acc_rd_valid    = 2'b00;
    bus.acc_rd_addr     = 64'd0;
    bus.acc_status      = 3'b001;
    bus.return_tag      = 2'd0;
    bus.return_index    = 32'd0;
    bus.proc_status_w   = 3'b000;
    bus.proc_addr_w     = 32'd0;
    bus.fetch_gnt       = 1'b0;
    bus.fetch_done      = 1'b0;
    bus.mem_rready      = 1'b1;
    bus.mem_rdata       = 32'd0;
    bus.mem_rdata_valid = 1'b0;

    // reset state, with requests pending that must not be granted
    next_cyc();
    bus.acc_rd_valid = 2'b11;
    #2;
    chk("rst_ready", bus.acc_rd_ready, 2'b00);
    chk("rst_acc_req", bus.acc_req, 1'b0);
    chk("rst_mem_ren", bus.mem_ren, 1'b0);
    chk("rst_fetch_req", bus.fetch_req, 1'b0);
    chk("rst_proc_status", bus.proc_status_r, 3'b000);
    chk("rst_fetch_cmd", bus.fetch_cmd, 2'b00);
    chk("rst_data_valid", bus.acc_rd_data_valid, 2'b00);
    next_cyc();
    rst_n = 1'b1;

    // table: single-cycle hits, arbitration and line alignment
    for (int i = 0; i < 7; i++) begin
      next_cyc();
      bus.acc_rd_valid = vecs[i].valid;
      bus.acc_rd_addr  = {vecs[i].a1, vecs[i].a0};
      bus.acc_status   = 3'b001;
      bus.return_tag   = vecs[i].tag;
      if (vecs[i].rv) drive_pop();
      #2;
      if (vecs[i].rv) check_pop();
      chk($sformatf("v%0d_ready", i), bus.acc_rd_ready, vecs[i].exp_ready);
      chk($sformatf("v%0d_acc_req", i), {bus.acc_req, bus.acc_cmd}, 3'b100);
      chk($sformatf("v%0d_index", i), bus.acc_index, vecs[i].exp_idx);
      chk($sformatf("v%0d_mem_ren", i), bus.mem_ren, 1'b1);
      chk($sformatf("v%0d_raddr", i), bus.mem_raddr, vecs[i].exp_raddr);
      exp_q.push_back('{vecs[i].exp_ch, mdata(vecs[i].exp_raddr)});
    end
    ret();

    // clean miss, no conflict: allocate, fetch, then read with touch
    next_cyc();
    bus.acc_rd_valid = 2'b01;
    bus.acc_rd_addr  = {32'h0000_0080, 32'h0000_0248};
    bus.acc_status   = 3'b000;
    #2;
    chk("a_ready", bus.acc_rd_ready, 2'b01);
    chk("a_mem_ren", bus.mem_ren, 1'b0);
    next_cyc();
    #2;
    chk("a_check_status", bus.proc_status_r, 3'b001);
    next_cyc();
    bus.return_tag   = 2'd2;
    bus.return_index = 32'h0000_0100;
    #2;
    chk("a_alloc_cmd", {bus.acc_req, bus.acc_cmd}, 3'b110);
    chk("a_alloc_status", bus.proc_status_r, 3'b010);
    next_cyc();
    #2;
    chk("a_fetch_req", bus.fetch_req, 1'b1);
    chk("a_fetch_cmd", bus.fetch_cmd, 2'b01);
    chk("a_fetch_tag", bus.fetch_tag, 2'd2);
    chk("a_fetch_pre", bus.fetch_addr_pre, 32'h0000_0100);
    chk("a_fetch_addr", bus.fetch_addr, 32'h0000_0240);
    next_cyc();
    bus.fetch_gnt = 1'b1;
    #2;
    chk("a_fetch_req_gnt", bus.fetch_req, 1'b1);
    next_cyc();
    #2;
    chk("a_wait_fetch", {bus.fetch_req, bus.proc_status_r}, 4'b0010);
    next_cyc();
    bus.fetch_done = 1'b1;
    next_cyc();
    bus.mem_rready = 1'b0;
    #2;
    chk("a_acc_mem_stall", {bus.mem_ren, bus.acc_req, bus.proc_status_r}, 5'b10010);
    chk("a_acc_mem_raddr", bus.mem_raddr, 7'h48);
    next_cyc();
    bus.mem_rready = 1'b1;
    #2;
    chk("a_touch", {bus.acc_req, bus.acc_cmd, bus.acc_tag}, 5'b11110);
    chk("a_done_status", bus.proc_status_r, 3'b011);
    exp_q.push_back('{0, mdata(7'h48)});
    next_cyc();
    #2;
    chk("a_back_idle", bus.mem_ren, 1'b0);
    ret();

    // dirty miss with write conflict on the same line, then re-lookup hit
    next_cyc();
    bus.acc_rd_valid = 2'b10;
    bus.acc_rd_addr  = {32'h0000_0300, 32'h0000_0000};
    bus.acc_status   = 3'b100;
    #2;
    chk("b_ready", bus.acc_rd_ready, 2'b10);
    next_cyc();
    bus.proc_status_w = 3'b010;
    bus.proc_addr_w   = 32'h0000_0300;
    #2;
    chk("b_check", {bus.proc_status_r, bus.proc_addr_r}, {3'b001, 32'h0000_0300});
    next_cyc();
    #2;
    chk("b_wait_conflict", {bus.acc_req, bus.fetch_req, bus.proc_status_r}, 5'b00000);
    next_cyc();
    bus.proc_status_w = 3'b011;
    next_cyc();
    bus.proc_status_w = 3'b000;
    bus.acc_status    = 3'b001;
    bus.return_tag    = 2'd3;
    #2;
    chk("b_relookup", {bus.acc_req, bus.acc_cmd, bus.mem_ren}, 4'b1000);
    chk("b_relookup_idx", bus.acc_index, 32'h0000_0300);
    next_cyc();
    #2;
    chk("b_acc_mem", {bus.mem_ren, bus.fetch_req, bus.acc_cmd, bus.acc_tag}, 6'b101111);
    chk("b_raddr", bus.mem_raddr, 7'h60);
    exp_q.push_back('{1, mdata(7'h60)});
    ret();

    // dirty miss, no conflict: writeback+fetch, then reset while waiting
    next_cyc();
    bus.acc_rd_valid = 2'b01;
    bus.acc_rd_addr  = {32'h0000_0000, 32'h0000_0400};
    bus.acc_status   = 3'b100;
    next_cyc();
    next_cyc();
    bus.return_tag   = 2'd1;
    bus.return_index = 32'h0000_0200;
    next_cyc();
    bus.fetch_gnt = 1'b1;
    #2;
    chk("c_fetch_cmd", {bus.fetch_req, bus.fetch_cmd}, 3'b110);
    next_cyc();
    bus.acc_rd_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    chk("c_rst_outs", {bus.fetch_req, bus.mem_ren, bus.acc_req, bus.acc_rd_ready}, 5'b00000);
    chk("c_rst_regs", {bus.fetch_cmd, bus.proc_status_r, bus.acc_rd_data_valid}, 7'b0);
    next_cyc();
    rst_n          = 1'b1;
    bus.fetch_done = 1'b1;
    next_cyc();
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 32'h1234_5678;
    #2;
    chk("c_no_resume", {bus.mem_ren, bus.fetch_req}, 2'b00);
    chk("c_empty_ignore", bus.acc_rd_data_valid, 2'b00);

    // response FIFO full blocks new grants until a pop
    bus.acc_status = 3'b001;
    next_cyc();
    bus.acc_rd_valid = 2'b01;
    bus.acc_rd_addr  = {32'h0000_0080, 32'h0000_0040};
    bus.return_tag   = 2'd1;
    #2;
    chk("d_g0", bus.acc_rd_ready, 2'b01);
    exp_q.push_back('{0, mdata(7'h20)});
    next_cyc();
    bus.acc_rd_valid = 2'b10;
    bus.return_tag   = 2'd2;
    #2;
    chk("d_g1", bus.acc_rd_ready, 2'b10);
    exp_q.push_back('{1, mdata(7'h40)});
    next_cyc();
    bus.acc_rd_valid = 2'b11;
    #2;
    chk("d_full_block", {bus.acc_rd_ready, bus.acc_req}, 3'b000);
    next_cyc();
    bus.acc_rd_valid = 2'b11;
    drive_pop();
    #2;
    check_pop();
    chk("d_full_pop_block", bus.acc_rd_ready, 2'b00);
    next_cyc();
    bus.acc_rd_valid = 2'b11;
    bus.return_tag   = 2'd3;
    #2;
    chk("d_reopen", bus.acc_rd_ready, 2'b01);
    chk("d_raddr", bus.mem_raddr, 7'h60);
    exp_q.push_back('{0, mdata(7'h60)});
    ret();
    ret();
    next_cyc();
    #2;
    chk("end_scoreboard", 64'(exp_q.size()), 64'd0);
    chk("end_pending", 64'(pend_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
